// File: rtl/gsensor_tilt_emu.sv
// Push-button driven X-axis tilt emulator: ramps, saturates and springs back to level once per tick.
// Optional output dither via a 16-bit LFSR is enabled with `define GSENS_EMU_NOISE_EN.
module gsensor_tilt_emu #(
    parameter int TICK_DIV    = 50000,
    parameter int STEP        = 16,
    parameter int RETURN_STEP = 8,
    parameter int MAX_MAG     = 500
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       center,
    output logic [9:0] oDIG,
    output logic       oG_INT2
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic signed [10:0] MAX_S  = 11'(MAX_MAG);
    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic signed [10:0] RET_S  = 11'(RETURN_STEP);

    typedef enum logic [1:0] {ST_LEVEL, ST_PUSH_L, ST_PUSH_R, ST_RETURN} state_t;

    // All arithmetic is done 11 bits wide so clamping happens before any wrap can occur.
    function automatic logic signed [9:0] sat10(input logic signed [10:0] x);
        logic signed [10:0] y;
        y = x;
        if (x > MAX_S) begin
            y = MAX_S;
        end else if (x < -MAX_S) begin
            y = -MAX_S;
        end
        return y[9:0];
    endfunction

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    state_t             state_q, state_d;
    logic signed [9:0]  value_q, value_d;
    logic signed [10:0] v_ext;
    logic signed [9:0]  out_cur, out_nxt;
    logic               int_q, int_d;
    logic               tick;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
        state_d = state_q;
        value_d = value_q;
        v_ext   = $signed({value_q[9], value_q});
        if (tick) begin
            if (center) begin
                value_d = '0;
                state_d = ST_LEVEL;
            end else if (btn_left && !btn_right) begin
                value_d = sat10(v_ext - STEP_S);
                state_d = ST_PUSH_L;
            end else if (btn_right && !btn_left) begin
                value_d = sat10(v_ext + STEP_S);
                state_d = ST_PUSH_R;
            end else if (state_q == ST_LEVEL || v_ext == 11'sd0) begin
                // LEVEL is only ever entered with a zero value, so it simply holds.
                value_d = '0;
                state_d = ST_LEVEL;
            end else begin
                if (v_ext > 11'sd0) begin
                    value_d = (v_ext > RET_S) ? sat10(v_ext - RET_S) : '0;
                end else begin
                    value_d = (v_ext < -RET_S) ? sat10(v_ext + RET_S) : '0;
                end
                state_d = (value_d == '0) ? ST_LEVEL : ST_RETURN;
            end
        end
    end

`ifdef GSENS_EMU_NOISE_EN
    logic [15:0]        lfsr_q, lfsr_d;
    logic signed [9:0]  dout_q;
    logic signed [10:0] dith;

    always_comb begin
        lfsr_d = lfsr_q;
        if (tick) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
        case (lfsr_d[1:0])
            2'b00:   dith = -11'sd1;
            2'b11:   dith = 11'sd1;
            default: dith = 11'sd0;
        endcase
        out_nxt = tick ? sat10($signed({value_d[9], value_d}) + dith) : dout_q;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lfsr_q <= 16'hACE1;
            dout_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            dout_q <= out_nxt;
        end
    end

    assign out_cur = dout_q;
`else
    assign out_nxt = value_d;
    assign out_cur = value_q;
`endif

    assign int_d = tick && (out_nxt != out_cur);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q   <= '0;
            state_q <= ST_LEVEL;
            value_q <= '0;
            int_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            value_q <= value_d;
            int_q   <= int_d;
        end
    end

    assign oDIG    = out_cur;
    assign oG_INT2 = int_q;

endmodule
